uart_rx_frame: RTL

- UART receiver; consumes the serial frames produced on the board-level uart line.
- Recovers each byte and checks parity and stop bit.
- Presents the byte to the command decoder as a one-cycle valid pulse with error qualifiers.
- Frame format: 1 start bit (0), 8 data bits MSB first, 1 parity bit (XOR of the 8 data bits), 1 stop bit (1), idle high.

---
 rtl/uart_rx_frame.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receiver: start/8 data MSB-first/even-XOR parity/stop, counters; UART_RX_MAJORITY_EN enables 3-sample voting
module uart_rx_frame #(
    parameter int BAUD_DIV = 868,
    parameter int HALF_DIV = BAUD_DIV / 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             uart_rx,
    output logic [7:0]       rx_data,
    output logic             rx_vld,
    output logic             rx_perr,
    output logic             rx_ferr,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF_DIV - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote cycle after counter zero consumes one clock, so reload one less to keep bit spacing.
    localparam logic [CW-1:0] BIT_LD = CW'(BAUD_DIV - 2);
`else
    localparam logic [CW-1:0] BIT_LD = CW'(BAUD_DIV - 1);
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;

    state_t        state;
    logic          sync1, sync2, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          p_rx;
    logic          bit_tick, bit_val;
    logic          frame_perr, frame_ferr;

`ifdef UART_RX_MAJORITY_EN
    logic maj1, maj0, maj_ph;
    assign bit_tick = maj_ph;
    assign bit_val  = (maj1 & maj0) | (maj1 & rx_s) | (maj0 & rx_s);
`else
    assign bit_tick = (cnt == '0);
    assign bit_val  = rx_s;
`endif

    assign frame_perr = (p_rx != ^shreg);
    assign frame_ferr = ~bit_val;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
            rx_s  <= sync2;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            p_rx      <= 1'b0;
            rx_data   <= 8'h00;
            rx_vld    <= 1'b0;
            rx_perr   <= 1'b0;
            rx_ferr   <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
`ifdef UART_RX_MAJORITY_EN
            maj1      <= 1'b1;
            maj0      <= 1'b1;
            maj_ph    <= 1'b0;
`endif
        end else begin
            rx_vld  <= 1'b0;
            rx_perr <= 1'b0;
            rx_ferr <= 1'b0;
            case (state)
                IDLE: begin
                    // sync2 low while rx_s high means rx_s falls on this edge.
                    if (!sync2 && rx_s) begin
                        cnt   <= HALF_LD;
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (bit_tick) begin
                        cnt <= BIT_LD;
`ifdef UART_RX_MAJORITY_EN
                        maj_ph <= 1'b0;
`endif
                        case (state)
                            START: begin
                                if (bit_val) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end else begin
                                    bit_idx <= '0;
                                    state   <= DATA;
                                end
                            end
                            DATA: begin
                                shreg   <= {shreg[6:0], bit_val};
                                bit_idx <= bit_idx + 3'd1;
                                if (bit_idx == 3'd7)
                                    state <= PARITY;
                            end
                            PARITY: begin
                                p_rx  <= bit_val;
                                state <= STOP;
                            end
                            STOP: begin
                                rx_data <= shreg;
                                rx_vld  <= 1'b1;
                                rx_perr <= frame_perr;
                                rx_ferr <= frame_ferr;
                                if (frame_perr || frame_ferr) begin
                                    if (err_cnt != '1)
                                        err_cnt <= err_cnt + 1'b1;
                                end else if (frame_cnt != '1) begin
                                    frame_cnt <= frame_cnt + 1'b1;
                                end
                                if (bit_val) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end else begin
                                    state <= WAIT_HI;
                                end
                            end
                            default: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end else begin
`ifdef UART_RX_MAJORITY_EN
                        if (cnt == CW'(1))
                            maj1 <= rx_s;
                        if (cnt == '0) begin
                            maj0   <= rx_s;
                            maj_ph <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
`else
                        cnt <= cnt - 1'b1;
`endif
                    end
                end
            endcase
        end
    end

endmodule
